// File: rtl/bp_be_prefetch_issue_arbiter.sv
// Round-robin arbiter that merges prefetch requests into a de-duplicated FIFO
// and issues them to dispatch under an outstanding-prefetch credit limit.
module bp_be_prefetch_issue_arbiter #(
  parameter int num_req_p            = 2,
  parameter int vaddr_width_p        = 39,
  parameter int block_offset_width_p = 6,
  parameter int fifo_els_p           = 4,
  parameter int filter_els_p         = 4,
  parameter int max_outstanding_p    = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_req_p-1:0]                     req_v_i,
  input  logic [num_req_p*vaddr_width_p-1:0]       req_vaddr_i,
  output logic [num_req_p-1:0]                     req_yumi_o,
  input  logic                                     flush_i,
  output logic                                     pref_v_o,
  output logic [vaddr_width_p-1:0]                 pref_vaddr_o,
  input  logic                                     pref_yumi_i,
  input  logic                                     pref_done_i,
  output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o,
  output logic                                     busy_o
);

  localparam int line_w_lp  = vaddr_width_p - block_offset_width_p;
  localparam int fifo_aw_lp = $clog2(fifo_els_p);
  localparam int filt_aw_lp = (filter_els_p > 1) ? $clog2(filter_els_p) : 1;
  localparam int rr_w_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int out_w_lp   = $clog2(max_outstanding_p + 1);

  logic [line_w_lp-1:0]    fifo_line_r [fifo_els_p];
  logic [fifo_els_p-1:0]   fifo_v_r;
  logic [fifo_aw_lp:0]     rd_ptr_r, wr_ptr_r;
  logic [line_w_lp-1:0]    filt_line_r [filter_els_p];
  logic [filter_els_p-1:0] filt_v_r;
  logic [filt_aw_lp-1:0]   filt_rp_r;
  logic [rr_w_lp-1:0]      rr_r;
  logic [out_w_lp-1:0]     outstanding_r;

  logic [vaddr_width_p-1:0] req_vaddr [num_req_p];
  logic                     empty, full, credit_ok, deq, done_ok;
  logic [line_w_lp-1:0]     head_line, grant_line;
  logic                     grant_v, dup, enq;
  logic [rr_w_lp-1:0]       grant_idx, cand;

  always_comb begin
    for (int i = 0; i < num_req_p; i++)
      req_vaddr[i] = req_vaddr_i[i*vaddr_width_p +: vaddr_width_p];
  end

  // Pointers carry a wrap bit so equal addresses distinguish full from empty.
  assign empty     = (rd_ptr_r == wr_ptr_r);
  assign full      = (rd_ptr_r[fifo_aw_lp-1:0] == wr_ptr_r[fifo_aw_lp-1:0])
                   && (rd_ptr_r[fifo_aw_lp] != wr_ptr_r[fifo_aw_lp]);
  assign head_line = fifo_line_r[rd_ptr_r[fifo_aw_lp-1:0]];
  assign credit_ok = (outstanding_r < out_w_lp'(max_outstanding_p));
  assign pref_v_o  = ~empty & credit_ok & ~flush_i & ~reset_i;
  assign deq       = pref_v_o & pref_yumi_i;
  assign done_ok   = pref_done_i & (outstanding_r != '0);

  assign pref_vaddr_o  = empty ? '0 : {head_line, {block_offset_width_p{1'b0}}};
  assign outstanding_o = outstanding_r;
  assign busy_o        = ~empty | (outstanding_r != '0);

  always_comb begin
    grant_v    = 1'b0;
    grant_idx  = '0;
    grant_line = '0;
    cand       = '0;
    if (~full & ~flush_i & ~reset_i) begin
      for (int k = 0; k < num_req_p; k++) begin
        cand = rr_w_lp'((int'(rr_r) + k) % num_req_p);
        if (!grant_v && req_v_i[cand]) begin
          grant_v    = 1'b1;
          grant_idx  = cand;
          grant_line = req_vaddr[cand][vaddr_width_p-1:block_offset_width_p];
        end
      end
    end
  end

  always_comb begin
    req_yumi_o = '0;
    if (grant_v) req_yumi_o[grant_idx] = 1'b1;
  end

  // A line already queued or recently issued is accepted but not re-queued.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < filter_els_p; i++)
      if (filt_v_r[i] && filt_line_r[i] == grant_line) dup = 1'b1;
    for (int i = 0; i < fifo_els_p; i++)
      if (fifo_v_r[i] && fifo_line_r[i] == grant_line) dup = 1'b1;
  end
  assign enq = grant_v & ~dup;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_v_r      <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      filt_v_r      <= '0;
      filt_rp_r     <= '0;
      rr_r          <= '0;
      outstanding_r <= '0;
    end else begin
      if (grant_v)
        rr_r <= (grant_idx == rr_w_lp'(num_req_p - 1)) ? '0 : grant_idx + rr_w_lp'(1);
      if (flush_i) begin
        fifo_v_r <= '0;
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        filt_v_r <= '0;
      end else begin
        if (enq) begin
          fifo_line_r[wr_ptr_r[fifo_aw_lp-1:0]] <= grant_line;
          fifo_v_r[wr_ptr_r[fifo_aw_lp-1:0]]    <= 1'b1;
          wr_ptr_r <= wr_ptr_r + 1'b1;
        end
        if (deq) begin
          fifo_v_r[rd_ptr_r[fifo_aw_lp-1:0]] <= 1'b0;
          rd_ptr_r               <= rd_ptr_r + 1'b1;
          filt_line_r[filt_rp_r] <= head_line;
          filt_v_r[filt_rp_r]    <= 1'b1;
          filt_rp_r <= (filt_rp_r == filt_aw_lp'(filter_els_p - 1)) ? '0 : filt_rp_r + 1'b1;
        end
      end
      if (deq && !done_ok)      outstanding_r <= outstanding_r + out_w_lp'(1);
      else if (!deq && done_ok) outstanding_r <= outstanding_r - out_w_lp'(1);
    end
  end

  done_without_outstanding_a: assert property (@(posedge clk_i) disable iff (reset_i)
    pref_done_i |-> (outstanding_r != '0));

endmodule

// File: tb/tb_bp_be_prefetch_issue_arbiter.sv
// Randomized bench for the prefetch issue arbiter against a queue-based model
// of FIFO contents, recently-issued lines, credits and round-robin order.
module tb_bp_be_prefetch_issue_arbiter;
  localparam int N  = 2;
  localparam int W  = 39;
  localparam int B  = 6;
  localparam int F  = 4;
  localparam int FL = 4;
  localparam int M  = 4;
  localparam int LW = W - B;
  localparam int OW = $clog2(M + 1);

  logic           clk = 1'b0;
  logic           reset, flush, pref_yumi, pref_done;
  logic [N-1:0]   req_v, req_yumi;
  logic [N*W-1:0] req_vaddr;
  logic           pref_v, busy;
  logic [W-1:0]   pref_vaddr;
  logic [OW-1:0]  outstanding;

  always #5 clk = ~clk;

  bp_be_prefetch_issue_arbiter #(
    .num_req_p(N), .vaddr_width_p(W), .block_offset_width_p(B),
    .fifo_els_p(F), .filter_els_p(FL), .max_outstanding_p(M)
  ) dut (
    .clk_i(clk), .reset_i(reset), .req_v_i(req_v), .req_vaddr_i(req_vaddr),
    .req_yumi_o(req_yumi), .flush_i(flush), .pref_v_o(pref_v),
    .pref_vaddr_o(pref_vaddr), .pref_yumi_i(pref_yumi), .pref_done_i(pref_done),
    .outstanding_o(outstanding), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: FIFO of lines, last-issued lines since flush (bounded by FL), credits, rr.
  logic [LW-1:0] m_fifo[$];
  logic [LW-1:0] m_filt[$];
  int            m_out;
  int            m_rr;
  logic [LW-1:0] lines [N];

  function automatic logic [LW-1:0] rand_line();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) return LW'(r);
    return LW'(32'h40 + $urandom_range(0, 11));
  endfunction

  initial begin
    int g, p_req, p_yumi, p_done, phase;
    logic dup, rst_c;
    logic [63:0] exp_yumi, exp_vaddr;
    logic exp_pv;

    reset = 1'b1; flush = 1'b0; pref_yumi = 1'b0; pref_done = 1'b0;
    req_v = '0; req_vaddr = '0;
    m_out = 0; m_rr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_yumi", 64'(req_yumi), 64'd0);
    check("rst_pref_v", 64'(pref_v), 64'd0);
    check("rst_vaddr", 64'(pref_vaddr), 64'd0);
    check("rst_out", 64'(outstanding), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      phase = (cyc / 400) % 4;
      p_req  = (phase == 2) ? 40 : 80;
      p_yumi = (phase == 0) ? 90 : (phase == 1) ? 90 : (phase == 2) ? 10 : 50;
      p_done = (phase == 0) ? 90 : (phase == 1) ? 10 : (phase == 2) ? 90 : 50;

      rst_c = ($urandom_range(0, 249) == 0);
      reset = rst_c;
      flush = !rst_c && ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        req_v[i] = ($urandom_range(0, 99) < p_req);
        lines[i] = rand_line();
        req_vaddr[i*W +: W] = {lines[i], B'($urandom())};
      end
      exp_pv    = !rst_c && !flush && m_fifo.size() > 0 && m_out < M;
      pref_yumi = exp_pv && ($urandom_range(0, 99) < p_yumi);
      pref_done = (m_out > 0) && ($urandom_range(0, 99) < p_done);
      #1;

      g = -1;
      if (!rst_c && !flush && m_fifo.size() < F)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_v[(m_rr + k) % N]) g = (m_rr + k) % N;
      exp_yumi  = (g >= 0) ? (64'd1 << g) : 64'd0;
      exp_vaddr = (m_fifo.size() > 0) ? 64'({m_fifo[0], {B{1'b0}}}) : 64'd0;

      check("req_yumi", 64'(req_yumi), exp_yumi);
      check("pref_v", 64'(pref_v), 64'(exp_pv));
      check("pref_vaddr", 64'(pref_vaddr), exp_vaddr);
      check("outstanding", 64'(outstanding), 64'(m_out));
      check("busy", 64'(busy), 64'(m_fifo.size() > 0 || m_out != 0));

      if (rst_c) begin
        m_fifo.delete(); m_filt.delete(); m_out = 0; m_rr = 0;
      end else begin
        dup = 1'b0;
        if (g >= 0) begin
          foreach (m_fifo[i]) if (m_fifo[i] == lines[g]) dup = 1'b1;
          foreach (m_filt[i]) if (m_filt[i] == lines[g]) dup = 1'b1;
          m_rr = (g + 1) % N;
        end
        if (pref_done && m_out > 0) m_out--;
        if (flush) begin
          m_fifo.delete(); m_filt.delete();
        end else begin
          if (pref_yumi) begin
            m_filt.push_back(m_fifo.pop_front());
            if (m_filt.size() > FL) void'(m_filt.pop_front());
            m_out++;
          end
          if (g >= 0 && !dup) m_fifo.push_back(lines[g]);
        end
      end
      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
